// File: rtl/msi_requestor.sv
// Processor-side MSI controller: classifies CPU accesses against a direct-mapped tag/state array
// and arbitrates for the bus to issue misses, upgrades and dirty-victim writebacks.
module msi_requestor #(
   parameter int ADDR_W  = 8,
   parameter int INDEX_W = 2
) (
   input  logic               i_Clk,
   input  logic               i_Reset,
   input  logic               i_CpuValid,
   input  logic               i_CpuWrite,
   input  logic [ADDR_W-1:0]  i_CpuAddr,
   output logic               o_CpuReady,
   output logic               o_BusReq,
   input  logic               i_BusGrant,
   output logic [1:0]         o_BusMessage,
   output logic               o_WriteBack,
   output logic [ADDR_W-1:0]  o_BusAddr,
   input  logic               i_SnoopValid,
   input  logic [INDEX_W-1:0] i_SnoopIndex,
   input  logic [1:0]         i_SnoopState
);

   localparam int LINES = 1 << INDEX_W;
   localparam int TAG_W = ADDR_W - INDEX_W;

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_WB_REQ    = 3'd1;
   localparam logic [2:0] S_WB_SEND   = 3'd2;
   localparam logic [2:0] S_MISS_REQ  = 3'd3;
   localparam logic [2:0] S_MISS_SEND = 3'd4;
   localparam logic [2:0] S_DONE      = 3'd5;

   localparam logic [1:0] ST_I = 2'd0;
   localparam logic [1:0] ST_S = 2'd1;
   localparam logic [1:0] ST_M = 2'd2;

   localparam logic [1:0] MSG_NONE = 2'd0;
   localparam logic [1:0] MSG_RM   = 2'd1;
   localparam logic [1:0] MSG_WM   = 2'd2;
   localparam logic [1:0] MSG_INV  = 2'd3;

   logic [1:0]         line_st  [LINES];
   logic [TAG_W-1:0]   line_tag [LINES];
   logic [2:0]         fsm;
   logic [ADDR_W-1:0]  req_addr;
   logic [1:0]         req_msg;
   logic [1:0]         req_new;
   logic [TAG_W-1:0]   vic_tag;

   logic [INDEX_W-1:0] cpu_idx;
   logic [TAG_W-1:0]   cpu_tag;
   logic [1:0]         cur_st;
   logic               match;
   logic               accept;
   logic [INDEX_W-1:0] req_idx;

   assign cpu_idx  = i_CpuAddr[INDEX_W-1:0];
   assign cpu_tag  = i_CpuAddr[ADDR_W-1:INDEX_W];
   assign cur_st   = line_st[cpu_idx];
   assign match    = (line_tag[cpu_idx] == cpu_tag) && (cur_st != ST_I);
   // o_CpuReady is still high in the first IDLE cycle; the held request must not be taken twice
   assign accept   = (fsm == S_IDLE) && i_CpuValid && !o_CpuReady;
   assign req_idx  = req_addr[INDEX_W-1:0];
   assign o_BusReq = (fsm == S_WB_REQ) || (fsm == S_MISS_REQ);

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         for (int i = 0; i < LINES; i++) begin
            line_st[i]  <= ST_I;
            line_tag[i] <= '0;
         end
         fsm          <= S_IDLE;
         req_addr     <= '0;
         req_msg      <= MSG_NONE;
         req_new      <= ST_I;
         vic_tag      <= '0;
         o_CpuReady   <= 1'b0;
         o_WriteBack  <= 1'b0;
         o_BusMessage <= MSG_NONE;
         o_BusAddr    <= '0;
      end else begin
         o_CpuReady   <= 1'b0;
         o_WriteBack  <= 1'b0;
         o_BusMessage <= MSG_NONE;
         o_BusAddr    <= '0;
         // Snoop first so that a local update to the same line later in this block takes priority
         if (i_SnoopValid)
            line_st[i_SnoopIndex] <= i_SnoopState;
         case (fsm)
            S_IDLE: begin
               if (accept) begin
                  req_addr <= i_CpuAddr;
                  vic_tag  <= line_tag[cpu_idx];
                  if (match && (!i_CpuWrite || cur_st == ST_M)) begin
                     fsm <= S_DONE;
                  end else if (match) begin
                     req_msg <= MSG_INV;
                     req_new <= ST_M;
                     fsm     <= S_MISS_REQ;
                  end else begin
                     req_msg <= i_CpuWrite ? MSG_WM : MSG_RM;
                     req_new <= i_CpuWrite ? ST_M : ST_S;
                     fsm     <= (cur_st == ST_M) ? S_WB_REQ : S_MISS_REQ;
                  end
               end
            end
            S_WB_REQ: begin
               if (i_BusGrant)
                  fsm <= S_WB_SEND;
            end
            S_WB_SEND: begin
               o_WriteBack      <= 1'b1;
               o_BusAddr        <= {vic_tag, req_idx};
               line_st[req_idx] <= ST_I;
               fsm              <= S_MISS_REQ;
            end
            S_MISS_REQ: begin
               // Losing the shared copy while waiting turns the upgrade into a full write miss
               if (i_SnoopValid && i_SnoopIndex == req_idx && i_SnoopState == ST_I
                   && req_msg == MSG_INV)
                  req_msg <= MSG_WM;
               if (i_BusGrant)
                  fsm <= S_MISS_SEND;
            end
            S_MISS_SEND: begin
               o_BusMessage      <= req_msg;
               o_BusAddr         <= req_addr;
               line_st[req_idx]  <= req_new;
               line_tag[req_idx] <= req_addr[ADDR_W-1:INDEX_W];
               fsm               <= S_DONE;
            end
            S_DONE: begin
               o_CpuReady <= 1'b1;
               fsm        <= S_IDLE;
            end
            default: fsm <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_msi_requestor.sv
// Directed bench for msi_requestor; expected bus/ready events are queued at issue time
// with the edge at which they must be sampled, and a monitor retires them.
module tb_msi_requestor;

   typedef struct {
      int         kind;     // 0 ready, 1 writeback, 2 message
      logic [7:0] addr;
      logic [1:0] msg;
      int         edge_no;
   } ev_t;

   logic       i_Clk = 1'b0;
   logic       i_Reset = 1'b1;
   logic       i_CpuValid = 1'b0;
   logic       i_CpuWrite = 1'b0;
   logic [7:0] i_CpuAddr = '0;
   logic       o_CpuReady;
   logic       o_BusReq;
   logic       i_BusGrant = 1'b1;
   logic [1:0] o_BusMessage;
   logic       o_WriteBack;
   logic [7:0] o_BusAddr;
   logic       i_SnoopValid = 1'b0;
   logic [1:0] i_SnoopIndex = '0;
   logic [1:0] i_SnoopState = '0;

   int  cyc = 0;
   int  n0 = 0;
   int  checks = 0;
   int  errors = 0;
   ev_t exp_q[$];

   msi_requestor #(.ADDR_W(8), .INDEX_W(2)) dut (
      .i_Clk(i_Clk), .i_Reset(i_Reset),
      .i_CpuValid(i_CpuValid), .i_CpuWrite(i_CpuWrite), .i_CpuAddr(i_CpuAddr),
      .o_CpuReady(o_CpuReady), .o_BusReq(o_BusReq), .i_BusGrant(i_BusGrant),
      .o_BusMessage(o_BusMessage), .o_WriteBack(o_WriteBack), .o_BusAddr(o_BusAddr),
      .i_SnoopValid(i_SnoopValid), .i_SnoopIndex(i_SnoopIndex), .i_SnoopState(i_SnoopState)
   );

   always #5 i_Clk = ~i_Clk;
   always @(posedge i_Clk) cyc <= cyc + 1;

   // Monitor: any ready / writeback / message cycle must match the head of the queue
   always @(negedge i_Clk) begin
      if (!i_Reset) begin
         if (o_CpuReady || o_WriteBack || o_BusMessage != 2'd0) begin
            int  k;
            ev_t e;
            k = o_CpuReady ? 0 : (o_WriteBack ? 1 : 2);
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_event kind=%0d addr=%h msg=%0d edge=%0d", k, o_BusAddr, o_BusMessage, cyc + 1);
            end else begin
               e = exp_q.pop_front();
               if (e.kind != k || e.addr != o_BusAddr || e.msg != o_BusMessage || e.edge_no != cyc + 1
                   || (o_WriteBack && o_BusMessage != 2'd0)) begin
                  errors++;
                  $display("FAIL event got kind=%0d addr=%h msg=%0d edge=%0d wb=%0b want kind=%0d addr=%h msg=%0d edge=%0d",
                           k, o_BusAddr, o_BusMessage, cyc + 1, o_WriteBack, e.kind, e.addr, e.msg, e.edge_no);
               end
            end
         end else if (o_BusAddr != 8'h00) begin
            checks++;
            errors++;
            $display("FAIL idle_busaddr got %h want 00", o_BusAddr);
         end
      end
   end

   task automatic expect_ev(input int kind, input logic [7:0] addr, input logic [1:0] msg, input int dly);
      ev_t e;
      e.kind = kind; e.addr = addr; e.msg = msg; e.edge_no = n0 + dly;
      exp_q.push_back(e);
   endtask

   task automatic issue(input logic w, input logic [7:0] a);
      @(negedge i_Clk);
      i_CpuWrite = w;
      i_CpuAddr  = a;
      i_CpuValid = 1'b1;
      n0 = cyc + 1;
   endtask

   task automatic wait_ready();
      int n = 0;
      do begin
         @(negedge i_Clk);
         n++;
      end while (!o_CpuReady && n < 40);
      if (!o_CpuReady) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout addr=%h got ready=0 want 1", i_CpuAddr);
      end
      i_CpuValid = 1'b0;
   endtask

   task automatic check_req(input string name, input logic want);
      checks++;
      if (o_BusReq !== want) begin
         errors++;
         $display("FAIL %s bus_req got %b want %b", name, o_BusReq, want);
      end
   endtask

   initial begin
      repeat (3) @(posedge i_Clk);
      @(negedge i_Clk);
      i_Reset = 1'b0;
      checks++;
      if ({o_CpuReady, o_BusReq, o_BusMessage, o_WriteBack, o_BusAddr} !== 13'd0) begin
         errors++;
         $display("FAIL reset_outputs got %h want 0", {o_CpuReady, o_BusReq, o_BusMessage, o_WriteBack, o_BusAddr});
      end

      // 1: read 0x05 from cold -> READ_MISS, line1 S tag1
      issue(1'b0, 8'h05);
      expect_ev(2, 8'h05, 2'd1, 3);
      expect_ev(0, 8'h00, 2'd0, 4);
      @(negedge i_Clk);
      check_req("miss_req_cycle1", 1'b1);
      wait_ready();

      // 2: read hit, then upgrade write
      issue(1'b0, 8'h05);
      expect_ev(0, 8'h00, 2'd0, 2);
      @(negedge i_Clk);
      check_req("hit_no_req", 1'b0);
      wait_ready();
      issue(1'b1, 8'h05);
      expect_ev(2, 8'h05, 2'd3, 3);
      expect_ev(0, 8'h00, 2'd0, 4);
      wait_ready();

      // 3: dirty victim -> writeback 0x05 then READ_MISS 0x09
      issue(1'b0, 8'h09);
      expect_ev(1, 8'h05, 2'd0, 3);
      expect_ev(2, 8'h09, 2'd1, 5);
      expect_ev(0, 8'h00, 2'd0, 6);
      wait_ready();

      // 4: bring 0x05 back as S, then upgrade race with delayed grant
      issue(1'b0, 8'h05);
      expect_ev(2, 8'h05, 2'd1, 3);
      expect_ev(0, 8'h00, 2'd0, 4);
      wait_ready();
      i_BusGrant = 1'b0;
      issue(1'b1, 8'h05);
      expect_ev(2, 8'h05, 2'd2, 8);
      expect_ev(0, 8'h00, 2'd0, 9);
      @(negedge i_Clk);
      @(negedge i_Clk);
      i_SnoopValid = 1'b1; i_SnoopIndex = 2'd1; i_SnoopState = 2'd0;
      @(negedge i_Clk);
      i_SnoopValid = 1'b0;
      @(negedge i_Clk);
      @(negedge i_Clk);
      check_req("req_held_no_grant", 1'b1);
      @(negedge i_Clk);
      i_BusGrant = 1'b1;
      wait_ready();
      issue(1'b0, 8'h05);
      expect_ev(0, 8'h00, 2'd0, 2);
      wait_ready();

      // 5: reset while in MISS_REQ aborts; state array cleared
      i_BusGrant = 1'b0;
      issue(1'b0, 8'h0A);
      @(negedge i_Clk);
      check_req("req_before_reset", 1'b1);
      i_Reset = 1'b1;
      @(negedge i_Clk);
      check_req("req_after_reset", 1'b0);
      i_Reset    = 1'b0;
      i_CpuValid = 1'b0;
      i_BusGrant = 1'b1;
      repeat (3) @(negedge i_Clk);
      issue(1'b0, 8'h05);
      expect_ev(2, 8'h05, 2'd1, 3);
      expect_ev(0, 8'h00, 2'd0, 4);
      wait_ready();

      // 6: snoop on the same edge as the local line write; local M must win
      issue(1'b1, 8'h0E);
      expect_ev(2, 8'h0E, 2'd2, 3);
      expect_ev(0, 8'h00, 2'd0, 4);
      @(negedge i_Clk);
      @(negedge i_Clk);
      i_SnoopValid = 1'b1; i_SnoopIndex = 2'd2; i_SnoopState = 2'd0;
      @(negedge i_Clk);
      i_SnoopValid = 1'b0;
      wait_ready();
      issue(1'b0, 8'h0E);
      expect_ev(0, 8'h00, 2'd0, 2);
      wait_ready();
      issue(1'b1, 8'h0E);
      expect_ev(0, 8'h00, 2'd0, 2);
      wait_ready();

      repeat (10) @(negedge i_Clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL pending_events got %0d want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
